// File: rtl/imm_instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_instr_encoder_if
// Description : Upstream and downstream valid/ready bundle for the immediate
//               instruction encoder.
//               The slave modport is the encoder's view of the bundle.
//               The master modport is the view of the loader and the IM writer.
//   in_valid/in_ready    : upstream handshake
//   in_type              : immediate format (00 I, 01 S, 10 B, 11 J)
//   in_imm               : signed immediate (byte offset for B/J)
//   in_base              : base instruction word (opcode/rd/rs/funct)
//   out_valid/out_ready  : downstream handshake
//   out_instr            : encoded instruction word
//   out_err              : immediate not representable (range-check builds only)
// Revision    : 1.0  initial release
// ============================================================================
interface imm_instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_type;
    logic [31:0] in_imm;
    logic [31:0] in_base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    modport slave (
        input  in_valid, in_type, in_imm, in_base, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );

    modport master (
        output in_valid, in_type, in_imm, in_base, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );
endinterface
`default_nettype wire

// File: rtl/imm_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : imm_instr_encoder
// Description : Packs a 32-bit signed immediate into the I/S/B/J field
//               positions of an RV32I instruction word. The immediate bits
//               replace the matching bits of a base word. The encoder is a
//               2-stage valid/ready pipeline with a combinational ready chain.
//               It buffers at most 2 words and keeps them in order.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   bus        : imm_instr_encoder_if.slave (upstream and downstream handshakes)
//   enc_count  : count of completed output handshakes (wraps)
// Options     : IMM_RANGE_CHECK_EN when defined flags an immediate that is not
//               representable on out_err. Such a word is still truncated and
//               emitted. When the macro is undefined, out_err is tied to 0.
// Revision    : 1.0  initial release
// ============================================================================
module imm_instr_encoder #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    imm_instr_encoder_if.slave    bus,
    output logic [CNT_W-1:0]      enc_count
);

    localparam logic [1:0] c_fmt_i = 2'b00;
    localparam logic [1:0] c_fmt_s = 2'b01;
    localparam logic [1:0] c_fmt_b = 2'b10;
    localparam logic [1:0] c_fmt_j = 2'b11;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef IMM_RANGE_CHECK_EN
    // The range check needs the upper bits of the immediate.
    localparam int c_imm_w = 32;
`else
    // The widest field is J, which uses imm[20:1].
    localparam int c_imm_w = 21;
`endif

    // Stage 1: captured request
    logic               r_s1_v;
    logic [1:0]         r_s1_type;
    logic [c_imm_w-1:0] r_s1_imm;
    logic [31:0]        r_s1_base;

    // Stage 2: encoded result
    logic               r_s2_v;
    logic [31:0]        r_s2_instr;
    logic               r_s2_err;

    logic [CNT_W-1:0]   r_enc_count;

    logic               w_s1_adv;
    logic               w_s2_adv;
    logic [31:0]        w_instr;
    logic               w_err;

    assign w_s2_adv = !r_s2_v || bus.out_ready;
    assign w_s1_adv = !r_s1_v || w_s2_adv;

    // Overwrite only the immediate fields and keep the other base bits.
    always_comb begin
        w_instr = r_s1_base;
        case (r_s1_type)
            c_fmt_i: begin
                w_instr[31:20] = r_s1_imm[11:0];
            end
            c_fmt_s: begin
                w_instr[31:25] = r_s1_imm[11:5];
                w_instr[11:7]  = r_s1_imm[4:0];
            end
            c_fmt_b: begin
                w_instr[31]    = r_s1_imm[12];
                w_instr[30:25] = r_s1_imm[10:5];
                w_instr[11:8]  = r_s1_imm[4:1];
                w_instr[7]     = r_s1_imm[11];
            end
            c_fmt_j: begin
                w_instr[31]    = r_s1_imm[20];
                w_instr[30:21] = r_s1_imm[10:1];
                w_instr[20]    = r_s1_imm[11];
                w_instr[19:12] = r_s1_imm[19:12];
            end
            default: begin
                w_instr = r_s1_base;
            end
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // An N-bit signed value fits when all bits from its sign bit up to bit 31
    // are equal.
    logic w_fit12;
    logic w_fit13;
    logic w_fit21;

    assign w_fit12 = (&r_s1_imm[31:11]) || !(|r_s1_imm[31:11]);
    assign w_fit13 = (&r_s1_imm[31:12]) || !(|r_s1_imm[31:12]);
    assign w_fit21 = (&r_s1_imm[31:20]) || !(|r_s1_imm[31:20]);

    always_comb begin
        w_err = 1'b0;
        case (r_s1_type)
            c_fmt_i, c_fmt_s: w_err = !w_fit12;
            c_fmt_b:          w_err = !w_fit13 || r_s1_imm[0];
            c_fmt_j:          w_err = !w_fit21 || r_s1_imm[0];
            default:          w_err = 1'b0;
        endcase
    end
`else
    assign w_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v      <= 1'b0;
            r_s1_type   <= 2'b00;
            r_s1_imm    <= '0;
            r_s1_base   <= 32'h0;
            r_s2_v      <= 1'b0;
            r_s2_instr  <= 32'h0;
            r_s2_err    <= 1'b0;
            r_enc_count <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_v <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1_type <= bus.in_type;
                    r_s1_imm  <= bus.in_imm[c_imm_w-1:0];
                    r_s1_base <= bus.in_base;
                end
            end
            // Stage 2 holds its data while stalled, so the output stays stable.
            if (w_s2_adv) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_s2_instr <= w_instr;
                    r_s2_err   <= w_err;
                end
            end
            if (r_s2_v && bus.out_ready) begin
                r_enc_count <= r_enc_count + c_cnt_one;
            end
        end
    end

    assign bus.in_ready  = w_s1_adv;
    assign bus.out_valid = r_s2_v;
    assign bus.out_instr = r_s2_instr;
    assign bus.out_err   = r_s2_err;
    assign enc_count     = r_enc_count;

endmodule
`default_nettype wire

// File: tb/tb_imm_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_instr_encoder
// Description : Self-checking bench for imm_instr_encoder.
//               The stimulus is a directed golden vector set followed by a
//               backpressure and reset sequence, then randomized traffic.
//               A reference model and an in-order scoreboard produce every
//               expected value.
//               Build with IMM_RANGE_CHECK_EN defined to check out_err.
// Revision    : 1.0  initial release
// ============================================================================
module tb_imm_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] enc_count;

    imm_instr_encoder_if bus();

    imm_instr_encoder #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .enc_count (enc_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] sb_q[$];    // expected {err, instr} for each word in flight
    logic [15:0] m_count;

    // Reference model: builds each format from its field layout and computes
    // representability with signed integer ranges.
    function automatic logic [32:0] model(input logic [1:0] t, input logic [31:0] imm,
                                          input logic [31:0] base);
        logic [31:0] ins;
        longint      s;
        logic        bad;
        s = longint'($signed(imm));
        case (t)
            2'b00:   ins = {imm[11:0], base[19:0]};
            2'b01:   ins = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
            2'b10:   ins = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
            default: ins = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        endcase
        case (t)
            2'b00, 2'b01: bad = (s < -2048) || (s > 2047);
            2'b10:        bad = (s < -4096) || (s > 4094) || imm[0];
            default:      bad = (s < -1048576) || (s > 1048574) || imm[0];
        endcase
`ifndef IMM_RANGE_CHECK_EN
        bad = 1'b0;
`endif
        return {bad, ins};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, score the output before the edge,
    // advance, and check the counter.
    task automatic cycle(input logic v, input logic [1:0] t, input logic [31:0] imm,
                         input logic [31:0] base, input logic ordy);
        bus.in_valid  = v;
        bus.in_type   = t;
        bus.in_imm    = imm;
        bus.in_base   = base;
        bus.out_ready = ordy;
        #3;
        chk("in_ready", bus.in_ready, (sb_q.size() < 2) || ordy);
        if (bus.out_valid) begin
            if (sb_q.size() == 0) begin
                chk("spurious_out_valid", bus.out_valid, 1'b0);
            end else begin
                chk("out_instr", bus.out_instr, sb_q[0][31:0]);
                chk("out_err", bus.out_err, sb_q[0][32]);
                if (ordy) begin
                    void'(sb_q.pop_front());
                    m_count++;
                end
            end
        end
        if (v && bus.in_ready) sb_q.push_back(model(t, imm, base));
        @(posedge clk);
        #1;
        chk("enc_count", enc_count, m_count);
    endtask

    // One word with an explicit expected result: check latency, the held
    // output, and the golden value, then drain the word.
    task automatic directed(input string tag, input logic [1:0] t, input logic [31:0] imm,
                            input logic [31:0] base, input logic [31:0] exp_i,
                            input logic exp_e);
        cycle(1'b1, t, imm, base, 1'b1);
        chk({tag, "_lat1"}, bus.out_valid, 1'b0);
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
        chk({tag, "_lat2"}, bus.out_valid, 1'b1);
        chk({tag, "_instr"}, bus.out_instr, exp_i);
        chk({tag, "_err"}, bus.out_err, exp_e);
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        m_count = '0;
    endtask

    function automatic logic [31:0] pick_imm();
        int bnd[14] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, -4098,
                        1048574, -1048576, 1048576, -1048578, 0, -1};
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 8191)) - 32'd4096;
            2:       return 32'(bnd[$urandom_range(0, 13)]);
            default: return 32'($urandom_range(0, 2097151)) - 32'd1048576;
        endcase
    endfunction

    initial begin
        logic e_on;
`ifdef IMM_RANGE_CHECK_EN
        e_on = 1'b1;
`else
        e_on = 1'b0;
`endif
        bus.in_valid  = 1'b0;
        bus.in_type   = 2'b00;
        bus.in_imm    = 32'h0;
        bus.in_base   = 32'h0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        m_count = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_instr", bus.out_instr, 32'h0);
        chk("rst_out_err", bus.out_err, 1'b0);
        chk("rst_enc_count", enc_count, 16'h0);

        // Golden vectors
        directed("I", 2'b00, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
        directed("S", 2'b01, 32'd8,         32'h0000_2023, 32'h0000_2423, 1'b0);
        directed("B", 2'b10, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
        directed("J", 2'b11, 32'd2048,      32'h0000_006F, 32'h0010_006F, 1'b0);
        chk("count_after_set", enc_count, 16'd4);

        // Range-check vectors; err is expected only in range-check builds
        directed("I_2048", 2'b00, 32'd2048, 32'h0000_0013, 32'h8000_0013, e_on);
        directed("B_6",    2'b10, 32'd6,    32'h0000_0063, 32'h0000_0363, 1'b0);
        directed("B_5",    2'b10, 32'd5,    32'h0000_0063, 32'h0000_0263, e_on);

        // Backpressure: two words fill the pipe and the third is refused
        cycle(1'b1, 2'b00, 32'd1, 32'h0000_0013, 1'b0);
        cycle(1'b1, 2'b01, 32'd2, 32'h0000_2023, 1'b0);
        chk("bp_in_ready_low", bus.in_ready, 1'b0);
        cycle(1'b1, 2'b10, 32'd4, 32'h0000_0063, 1'b0);
        chk("bp_held_count", 64'(sb_q.size()), 64'd2);
        for (int i = 0; i < 4; i++) cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        chk("bp_drained", 64'(sb_q.size()), 64'd0);

        // Reset while stalled drops held words
        cycle(1'b1, 2'b11, 32'd16, 32'h0000_006F, 1'b0);
        cycle(1'b1, 2'b00, 32'd7,  32'h0000_0013, 1'b0);
        chk("rs_out_valid_pre", bus.out_valid, 1'b1);
        do_reset();
        chk("rs_out_valid", bus.out_valid, 1'b0);
        chk("rs_enc_count", enc_count, 16'h0);
        chk("rs_out_instr", bus.out_instr, 32'h0);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), pick_imm(), $urandom,
                  1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        chk("final_drained", 64'(sb_q.size()), 64'd0);
        chk("final_out_valid", bus.out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
